mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one 16-bit sequential unsigned multiplier among NREQ requesters. It accepts requests, latches the operands and issues a single-cycle start to the multiplier. It waits for the multiplier's done, then returns the 32-bit product to the granted requester. A watchdog aborts an operation if done never returns. The block sits between the client blocks and the multiplier instance; only one operation is outstanding at a time.

---
 rtl/mult_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential N x N multiplier.
// Ports:
//   clk, resetb           clock, async active-low reset
//   req/req_a/req_b       per-requester request level and packed operands
//   gnt                   one-hot pulse when a requester's operands are taken
//   rsp_valid/rsp_data    one-hot result pulse with the 2N-bit product
//   rsp_err               result was a watchdog abort (rsp_data = 0)
//   busy                  an operation is in flight
//   m_start/m_ain/m_bin   start pulse and registered operands to multiplier
//   m_done/m_yout         multiplier done level and product
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int N       = 16,
    parameter int TIMEOUT = 24
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*N-1:0]    rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              m_start,
    output logic [N-1:0]      m_ain,
    output logic [N-1:0]      m_bin,
    input  logic              m_done,
    input  logic [2*N-1:0]    m_yout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [N-1:0]    ain_q, ain_d;
    logic [N-1:0]    bin_q, bin_d;
    logic [2*N-1:0]  data_q, data_d;
    logic            err_q, err_d;

    logic            win_found;
    logic [IW-1:0]   win_id;
    logic [N-1:0]    win_a;
    logic [N-1:0]    win_b;

    // Scan from the far end toward rr_q so the requester closest
    // to the pointer (upward, with wrap) is the last to overwrite.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_a     = '0;
        win_b     = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[(int'(rr_q) + j) % NREQ]) begin
                win_found = 1'b1;
                win_id    = IW'((int'(rr_q) + j) % NREQ);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IW'(i)) begin
                win_a = req_a[i*N +: N];
                win_b = req_b[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        timer_d = timer_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                // A low m_done here means the multiplier is still
                // busy with something; hold off granting.
                if (win_found && m_done) begin
                    id_d    = win_id;
                    ain_d   = win_a;
                    bin_d   = win_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    data_d  = m_yout;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                rr_d    = (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            timer_q <= '0;
            ain_q   <= '0;
            bin_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            timer_q <= timer_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i]       = (state_q == ISSUE) && (id_q == IW'(i));
            rsp_valid[i] = (state_q == RESP) && (id_q == IW'(i));
        end
    end

    assign m_start  = (state_q == ISSUE);
    assign busy     = (state_q != IDLE);
    assign m_ain    = ain_q;
    assign m_bin    = bin_q;
    assign rsp_data = data_q;
    assign rsp_err  = err_q;

endmodule
